// File: rtl/vend_txn_checker.sv
// Vending transaction front end: coin credit, selection check, abort/timeout refund.
// Result code, dispense and change are all registered for the display stage.
module vend_txn_checker #(
  parameter int CREDIT_W    = 8,
  parameter int MAX_CREDIT  = 255,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_coin_valid,
  input  logic [1:0]          i_coin_value,
  input  logic                i_sel_valid,
  input  logic [CREDIT_W-1:0] i_item_price,
  input  logic                i_item_empty,
  input  logic                i_cancel,
  output logic [CREDIT_W-1:0] o_credit,
  output logic                o_coin_reject,
  output logic [1:0]          o_check,
  output logic                o_check_valid,
  output logic                o_dispense,
  output logic [CREDIT_W-1:0] o_change
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] LP_TLAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [CREDIT_W:0] LP_MAX = (CREDIT_W + 1)'(MAX_CREDIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_EVAL
  } state_t;

  state_t              r_state, w_state;
  logic [CREDIT_W-1:0] r_credit, w_credit;
  logic [TW-1:0]       r_timer, w_timer;
  logic [CREDIT_W-1:0] r_price, w_price;
  logic                r_empty, w_empty;
  logic [1:0]          r_check, w_check;
  logic                r_cv, w_cv;
  logic                r_disp, w_disp;
  logic [CREDIT_W-1:0] r_change, w_change;
  logic                r_rej, w_rej;

  logic [CREDIT_W:0]   w_coin_amt;
  logic [CREDIT_W:0]   w_sum;
  logic                w_sat;
  logic [CREDIT_W-1:0] w_credit_add;

  always_comb begin
    case (i_coin_value)
      2'b00:   w_coin_amt = (CREDIT_W + 1)'(1);
      2'b01:   w_coin_amt = (CREDIT_W + 1)'(2);
      2'b10:   w_coin_amt = (CREDIT_W + 1)'(5);
      default: w_coin_amt = (CREDIT_W + 1)'(10);
    endcase
  end

  // A coin that would overflow the ceiling is refused; credit stays put.
  assign w_sum = {1'b0, r_credit} + w_coin_amt;
  assign w_sat = w_sum > LP_MAX;
  assign w_credit_add = (i_coin_valid && !w_sat) ?
                        w_sum[CREDIT_W-1:0] : r_credit;

  always_comb begin
    w_state  = r_state;
    w_credit = r_credit;
    w_timer  = r_timer;
    w_price  = r_price;
    w_empty  = r_empty;
    w_check  = r_check;
    w_change = r_change;
    w_cv     = 1'b0;
    w_disp   = 1'b0;
    w_rej    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_rej    = i_coin_valid && w_sat;
        w_credit = w_credit_add;
        if (i_sel_valid) begin
          w_price = i_item_price;
          w_empty = i_item_empty;
          w_state = S_EVAL;
        end else if (i_coin_valid) begin
          w_timer = '0;
          w_state = S_COLLECT;
        end
      end
      S_COLLECT: begin
        w_rej = i_coin_valid && w_sat;
        if (i_cancel || (!i_coin_valid && !i_sel_valid &&
                         r_timer == LP_TLAST)) begin
          w_check  = 2'b11;
          w_cv     = 1'b1;
          w_change = w_credit_add;
          w_credit = '0;
          w_state  = S_IDLE;
        end else if (i_sel_valid) begin
          w_credit = w_credit_add;
          w_price  = i_item_price;
          w_empty  = i_item_empty;
          w_state  = S_EVAL;
        end else if (i_coin_valid) begin
          w_credit = w_credit_add;
          w_timer  = '0;
        end else begin
          w_timer = r_timer + 1'b1;
        end
      end
      S_EVAL: begin
        w_rej   = i_coin_valid;
        w_cv    = 1'b1;
        w_timer = '0;
        if (r_empty || r_credit < r_price) begin
          w_check  = r_empty ? 2'b10 : 2'b01;
          w_change = '0;
          w_state  = (r_credit != '0) ? S_COLLECT : S_IDLE;
        end else begin
          w_check  = 2'b00;
          w_disp   = 1'b1;
          w_change = r_credit - r_price;
          w_credit = '0;
          w_state  = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_credit <= '0;
      r_timer  <= '0;
      r_price  <= '0;
      r_empty  <= 1'b0;
      r_check  <= 2'b00;
      r_cv     <= 1'b0;
      r_disp   <= 1'b0;
      r_change <= '0;
      r_rej    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_credit <= w_credit;
      r_timer  <= w_timer;
      r_price  <= w_price;
      r_empty  <= w_empty;
      r_check  <= w_check;
      r_cv     <= w_cv;
      r_disp   <= w_disp;
      r_change <= w_change;
      r_rej    <= w_rej;
    end
  end

  assign o_credit      = r_credit;
  assign o_coin_reject = r_rej;
  assign o_check       = r_check;
  assign o_check_valid = r_cv;
  assign o_dispense    = r_disp;
  assign o_change      = r_change;

endmodule

// File: tb/tb_vend_txn_checker.sv
// Directed-vector bench for vend_txn_checker.
// Expected values below are worked out by hand from the transaction rules.
module tb_vend_txn_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_valid;
  logic [1:0] coin_value;
  logic       sel_valid;
  logic [7:0] item_price;
  logic       item_empty;
  logic       cancel;
  logic [7:0] credit;
  logic       coin_reject;
  logic [1:0] check;
  logic       check_valid;
  logic       dispense;
  logic [7:0] change;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [1:0] C1 = 2'b00;
  localparam logic [1:0] C2 = 2'b01;
  localparam logic [1:0] C5 = 2'b10;
  localparam logic [1:0] C10 = 2'b11;

  vend_txn_checker dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_coin_valid (coin_valid),
    .i_coin_value (coin_value),
    .i_sel_valid  (sel_valid),
    .i_item_price (item_price),
    .i_item_empty (item_empty),
    .i_cancel     (cancel),
    .o_credit     (credit),
    .o_coin_reject(coin_reject),
    .o_check      (check),
    .o_check_valid(check_valid),
    .o_dispense   (dispense),
    .o_change     (change)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    coin_valid = 1'b0;
    sel_valid  = 1'b0;
    cancel     = 1'b0;
    item_empty = 1'b0;
  endtask

  task automatic coin(input logic [1:0] v);
    coin_valid = 1'b1;
    coin_value = v;
    tick();
  endtask

  task automatic sel(input logic [7:0] p, input logic e);
    sel_valid  = 1'b1;
    item_price = p;
    item_empty = e;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    coin_valid = 1'b0;
    coin_value = 2'b00;
    sel_valid = 1'b0;
    item_price = 8'd0;
    item_empty = 1'b0;
    cancel = 1'b0;
    tick();
    tick();
    chk("rst_credit", credit, 0);
    chk("rst_check", check, 0);
    chk("rst_change", change, 0);
    chk("rst_cv", check_valid, 0);
    chk("rst_disp", dispense, 0);
    chk("rst_rej", coin_reject, 0);
    rst = 1'b0;
    tick();

    // 1: coins 10,5 then price 12
    coin(C10);
    chk("t1_credit10", credit, 10);
    coin(C5);
    chk("t1_credit15", credit, 15);
    sel(8'd12, 1'b0);
    chk("t1_cv_early", check_valid, 0);
    tick();
    chk("t1_check", check, 0);
    chk("t1_cv", check_valid, 1);
    chk("t1_disp", dispense, 1);
    chk("t1_change", change, 3);
    chk("t1_credit", credit, 0);
    tick();
    chk("t1_cv_pulse", check_valid, 0);
    chk("t1_disp_pulse", dispense, 0);
    chk("t1_change_hold", change, 3);

    // 2: coin 2, price 5 -> insufficient, stays in COLLECT
    coin(C2);
    sel(8'd5, 1'b0);
    tick();
    chk("t2_check", check, 1);
    chk("t2_cv", check_valid, 1);
    chk("t2_disp", dispense, 0);
    chk("t2_credit", credit, 2);
    chk("t2_change", change, 0);
    cancel = 1'b1;
    tick();
    chk("t2_abort_check", check, 3);
    chk("t2_abort_change", change, 2);
    chk("t2_abort_credit", credit, 0);

    // 3: coin 10, sold out, then cancel
    coin(C10);
    sel(8'd3, 1'b1);
    tick();
    chk("t3_check", check, 2);
    chk("t3_credit", credit, 10);
    chk("t3_change", change, 0);
    cancel = 1'b1;
    tick();
    chk("t3_abort_check", check, 3);
    chk("t3_abort_change", change, 10);
    chk("t3_abort_cv", check_valid, 1);

    // 4: coin 1 then idle until timeout
    coin(C1);
    for (int i = 0; i < 999; i++) tick();
    chk("t4_pre_cv", check_valid, 0);
    chk("t4_pre_credit", credit, 1);
    tick();
    chk("t4_check", check, 3);
    chk("t4_cv", check_valid, 1);
    chk("t4_change", change, 1);
    chk("t4_credit", credit, 0);
    cancel = 1'b1;
    tick();
    chk("t4_idle_cancel_cv", check_valid, 0);

    // 5: saturation and same-cycle interactions
    for (int i = 0; i < 25; i++) coin(C10);
    chk("t5_credit250", credit, 250);
    coin(C10);
    chk("t5_rej", coin_reject, 1);
    chk("t5_rej_credit", credit, 250);
    coin(C5);
    chk("t5_max_rej", coin_reject, 0);
    chk("t5_max_credit", credit, 255);
    coin(C1);
    chk("t5_over_rej", coin_reject, 1);
    cancel = 1'b1;
    tick();
    chk("t5_refund", change, 255);
    coin_valid = 1'b1;
    coin_value = C5;
    sel(8'd4, 1'b0);
    chk("t5_pre_eval_credit", credit, 5);
    tick();
    chk("t5_cs_check", check, 0);
    chk("t5_cs_change", change, 1);
    coin(C2);
    sel(8'd1, 1'b0);
    coin(C10);
    chk("t5_eval_rej", coin_reject, 1);
    chk("t5_eval_change", change, 1);
    chk("t5_eval_credit", credit, 0);
    coin(C2);
    cancel = 1'b1;
    sel_valid = 1'b1;
    item_price = 8'd1;
    coin(C1);
    chk("t5_cxl_check", check, 3);
    chk("t5_cxl_change", change, 3);
    chk("t5_cxl_disp", dispense, 0);
    tick();
    chk("t5_cxl_no_eval", check_valid, 0);

    // 6: reset while in EVAL
    coin(C10);
    sel(8'd3, 1'b0);
    rst = 1'b1;
    tick();
    chk("t6_credit", credit, 0);
    chk("t6_disp", dispense, 0);
    chk("t6_cv", check_valid, 0);
    chk("t6_check", check, 0);
    chk("t6_change", change, 0);
    rst = 1'b0;
    tick();
    chk("t6_no_late_disp", dispense, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
